// File: rtl/pp_gen_seq_if.sv
// rtl/pp_gen_seq_if.sv - operand/row handshake bundle for the partial-product generator
interface pp_gen_seq_if;
    logic       in_valid;
    logic       in_ready;
    logic [3:0] a;
    logic [3:0] b;
    logic       out_valid;
    logic       out_ready;
    logic [3:0] pp0;
    logic [3:0] pp1;
    logic [3:0] pp2;
    logic [3:0] pp3;

    modport master (
        output in_valid, a, b, out_ready,
        input  in_ready, out_valid, pp0, pp1, pp2, pp3
    );

    modport slave (
        input  in_valid, a, b, out_ready,
        output in_ready, out_valid, pp0, pp1, pp2, pp3
    );
endinterface

// File: rtl/pp_gen_seq.sv
// rtl/pp_gen_seq.sv - sequential 4x4 signed partial-product row generator, one row per cycle
module pp_gen_seq (
    input  logic         clk,
    input  logic         rst,
    pp_gen_seq_if.slave  bus
);

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_GEN  = 2'd1,
        ST_HOLD = 2'd2
    } state_t;

    state_t     r_state;
    state_t     w_state_nxt;
    logic [1:0] r_cnt;
    logic [3:0] r_a_q;
    logic [3:0] r_b_q;
    logic [3:0] r_pp0;
    logic [3:0] r_pp1;
    logic [3:0] r_pp2;
    logic [3:0] r_pp3;

    logic       w_in_ready;
    logic       w_out_valid;
    logic       w_gen;
    logic       w_accept;
    logic       w_last_row;
    logic [3:0] w_row;

    assign w_accept   = w_in_ready && bus.in_valid;
    assign w_last_row = (r_cnt == 2'd3);
    // pp3 stays uninverted; the reduction stage owns the sign correction.
    assign w_row      = r_a_q & {4{r_b_q[r_cnt]}};

    always_ff @(posedge clk) begin
        if (rst) begin
            r_state <= ST_IDLE;
        end else begin
            r_state <= w_state_nxt;
        end
    end

    always_comb begin
        w_state_nxt = r_state;
        unique case (r_state)
            ST_IDLE: if (w_accept)      w_state_nxt = ST_GEN;
            ST_GEN:  if (w_last_row)    w_state_nxt = ST_HOLD;
            ST_HOLD: if (bus.out_ready) w_state_nxt = ST_IDLE;
            default:                    w_state_nxt = ST_IDLE;
        endcase
    end

    always_comb begin
        w_in_ready  = 1'b0;
        w_out_valid = 1'b0;
        w_gen       = 1'b0;
        unique case (r_state)
            ST_IDLE: w_in_ready  = !rst;
            ST_GEN:  w_gen       = 1'b1;
            ST_HOLD: w_out_valid = 1'b1;
            default: w_in_ready  = 1'b0;
        endcase
    end

    // Rows are only touched on accept and during GEN, so they survive HOLD and IDLE.
    always_ff @(posedge clk) begin
        if (rst) begin
            r_cnt <= 2'd0;
            r_a_q <= 4'd0;
            r_b_q <= 4'd0;
            r_pp0 <= 4'd0;
            r_pp1 <= 4'd0;
            r_pp2 <= 4'd0;
            r_pp3 <= 4'd0;
        end else if (w_accept) begin
            r_cnt <= 2'd0;
            r_a_q <= bus.a;
            r_b_q <= bus.b;
            r_pp0 <= 4'd0;
            r_pp1 <= 4'd0;
            r_pp2 <= 4'd0;
            r_pp3 <= 4'd0;
        end else if (w_gen) begin
            unique case (r_cnt)
                2'd0: r_pp0 <= w_row;
                2'd1: r_pp1 <= w_row;
                2'd2: r_pp2 <= w_row;
                2'd3: r_pp3 <= w_row;
                default: r_pp0 <= w_row;
            endcase
            r_cnt <= r_cnt + 2'd1;
        end
    end

    assign bus.in_ready  = w_in_ready;
    assign bus.out_valid = w_out_valid;
    assign bus.pp0       = r_pp0;
    assign bus.pp1       = r_pp1;
    assign bus.pp2       = r_pp2;
    assign bus.pp3       = r_pp3;

endmodule

// File: tb/tb_pp_gen_seq.sv
// tb/tb_pp_gen_seq.sv - scoreboard bench for pp_gen_seq with a signed reduction model
module tb_pp_gen_seq;

    logic clk = 1'b0;
    logic rst;

    pp_gen_seq_if bus_if ();

    pp_gen_seq dut (
        .clk (clk),
        .rst (rst),
        .bus (bus_if)
    );

    always #5 clk = ~clk;

    typedef struct packed {
        logic [3:0] a;
        logic [3:0] b;
        logic [3:0] p0;
        logic [3:0] p1;
        logic [3:0] p2;
        logic [3:0] p3;
    } exp_t;

    exp_t sb[$];
    int   n_pass  = 0;
    int   n_total = 0;

    // Signed row sum: rows 0..2 weigh +2^i, row 3 carries the multiplier sign bit.
    function automatic logic [7:0] reduce(input logic [3:0] r0, r1, r2, r3);
        int v0, v1, v2, v3, s;
        v0 = {{28{r0[3]}}, r0};
        v1 = {{28{r1[3]}}, r1};
        v2 = {{28{r2[3]}}, r2};
        v3 = {{28{r3[3]}}, r3};
        s  = v0 + (v1 * 2) + (v2 * 4) - (v3 * 8);
        return s[7:0];
    endfunction

    function automatic logic [7:0] smul(input logic [3:0] ta, tb_);
        int ea, eb, p;
        ea = {{28{ta[3]}}, ta};
        eb = {{28{tb_[3]}}, tb_};
        p  = ea * eb;
        return p[7:0];
    endfunction

    task automatic send(input logic [3:0] ta, input logic [3:0] tb_, output bit acc);
        exp_t e;
        @(negedge clk);
        bus_if.in_valid = 1'b1;
        bus_if.a        = ta;
        bus_if.b        = tb_;
        acc             = bus_if.in_ready;
        e.a  = ta;
        e.b  = tb_;
        e.p0 = tb_[0] ? ta : 4'd0;
        e.p1 = tb_[1] ? ta : 4'd0;
        e.p2 = tb_[2] ? ta : 4'd0;
        e.p3 = tb_[3] ? ta : 4'd0;
        sb.push_back(e);
        @(posedge clk);
        #1;
        bus_if.in_valid = 1'b0;
    endtask

    task automatic wait_valid(output int lat);
        lat = 0;
        while (lat < 20) begin
            @(negedge clk);
            if (bus_if.out_valid === 1'b1) break;
            lat++;
        end
    endtask

    task automatic finish_xfer();
        bus_if.out_ready = 1'b1;
        @(negedge clk);
        bus_if.out_ready = 1'b0;
    endtask

    task automatic test_reset();
        rst              = 1'b1;
        bus_if.in_valid  = 1'b0;
        bus_if.a         = 4'd0;
        bus_if.b         = 4'd0;
        bus_if.out_ready = 1'b0;
        repeat (2) @(negedge clk);
        n_total++;
        if ({bus_if.in_ready, bus_if.out_valid} !== 2'b00)
            $display("FAIL reset_hs: in_ready/out_valid=%b want 00", {bus_if.in_ready, bus_if.out_valid});
        else n_pass++;
        n_total++;
        if ({bus_if.pp0, bus_if.pp1, bus_if.pp2, bus_if.pp3} !== 16'h0000)
            $display("FAIL reset_rows: rows=%h want 0000", {bus_if.pp0, bus_if.pp1, bus_if.pp2, bus_if.pp3});
        else n_pass++;
        rst = 1'b0;
        #1;
        n_total++;
        if (bus_if.in_ready !== 1'b1)
            $display("FAIL reset_release: in_ready=%b want 1", bus_if.in_ready);
        else n_pass++;
    endtask

    task automatic test_vector(input logic [3:0] ta, input logic [3:0] tb_, input logic [7:0] want_prod);
        bit   acc;
        int   lat;
        exp_t e;
        logic [15:0] rows;
        send(ta, tb_, acc);
        n_total++;
        if (acc !== 1'b1) $display("FAIL vec_accept a=%b b=%b: in_ready=%b want 1", ta, tb_, acc);
        else n_pass++;
        wait_valid(lat);
        n_total++;
        if (lat !== 4) $display("FAIL vec_latency a=%b b=%b: latency=%0d want 4", ta, tb_, lat);
        else n_pass++;
        e    = sb.pop_front();
        rows = {bus_if.pp3, bus_if.pp2, bus_if.pp1, bus_if.pp0};
        n_total++;
        if (rows !== {e.p3, e.p2, e.p1, e.p0})
            $display("FAIL vec_rows a=%b b=%b: pp3..pp0=%h want %h", ta, tb_, rows, {e.p3, e.p2, e.p1, e.p0});
        else n_pass++;
        n_total++;
        if (reduce(bus_if.pp0, bus_if.pp1, bus_if.pp2, bus_if.pp3) !== want_prod)
            $display("FAIL vec_product a=%b b=%b: product=%h want %h", ta, tb_,
                     reduce(bus_if.pp0, bus_if.pp1, bus_if.pp2, bus_if.pp3), want_prod);
        else n_pass++;
        finish_xfer();
        n_total++;
        if ({bus_if.out_valid, bus_if.in_ready} !== 2'b01)
            $display("FAIL vec_complete: out_valid/in_ready=%b want 01", {bus_if.out_valid, bus_if.in_ready});
        else n_pass++;
        n_total++;
        if ({bus_if.pp3, bus_if.pp2, bus_if.pp1, bus_if.pp0} !== rows)
            $display("FAIL vec_retain: rows=%h want %h", {bus_if.pp3, bus_if.pp2, bus_if.pp1, bus_if.pp0}, rows);
        else n_pass++;
    endtask

    task automatic test_backpressure();
        bit   acc;
        int   lat;
        exp_t e;
        bit   ok;
        send(4'b1011, 4'b0110, acc);
        for (int i = 0; i < 4; i++) begin
            @(negedge clk);
            bus_if.in_valid = (i < 3) ? ~bus_if.in_valid : 1'b0;
            bus_if.a        = 4'($urandom);
            bus_if.b        = 4'($urandom);
            bus_if.out_ready = (i < 3) ? 1'b1 : 1'b0;
        end
        wait_valid(lat);
        e = sb.pop_front();
        n_total++;
        if (lat >= 20) $display("FAIL bp_timeout: out_valid not seen within %0d cycles", lat);
        else n_pass++;
        ok = 1'b1;
        for (int i = 0; i < 4; i++) begin
            if (bus_if.out_valid !== 1'b1 ||
                {bus_if.pp3, bus_if.pp2, bus_if.pp1, bus_if.pp0} !== {e.p3, e.p2, e.p1, e.p0}) begin
                $display("FAIL bp_hold cycle %0d: out_valid=%b rows=%h want 1 %h", i, bus_if.out_valid,
                         {bus_if.pp3, bus_if.pp2, bus_if.pp1, bus_if.pp0}, {e.p3, e.p2, e.p1, e.p0});
                ok = 1'b0;
            end
            if (i < 3) @(negedge clk);
        end
        n_total++;
        if (ok) n_pass++;
        finish_xfer();
        n_total++;
        if ({bus_if.out_valid, bus_if.in_ready} !== 2'b01)
            $display("FAIL bp_release: out_valid/in_ready=%b want 01", {bus_if.out_valid, bus_if.in_ready});
        else n_pass++;
    endtask

    task automatic test_reset_mid_gen();
        bit acc;
        bit seen;
        exp_t e;
        send(4'b0110, 4'b1111, acc);
        @(negedge clk);
        @(negedge clk);
        rst = 1'b1;
        @(negedge clk);
        n_total++;
        if (bus_if.in_ready !== 1'b0) $display("FAIL rst_mid_ready: in_ready=%b want 0", bus_if.in_ready);
        else n_pass++;
        rst = 1'b0;
        #1;
        n_total++;
        if ({bus_if.out_valid, bus_if.in_ready, bus_if.pp3, bus_if.pp2, bus_if.pp1, bus_if.pp0} !== 18'b01_0000_0000_0000_0000)
            $display("FAIL rst_mid_state: out_valid=%b in_ready=%b rows=%h want 0 1 0000", bus_if.out_valid,
                     bus_if.in_ready, {bus_if.pp3, bus_if.pp2, bus_if.pp1, bus_if.pp0});
        else n_pass++;
        e    = sb.pop_front();
        seen = 1'b0;
        repeat (8) begin
            @(negedge clk);
            if (bus_if.out_valid === 1'b1) seen = 1'b1;
        end
        n_total++;
        if (seen) $display("FAIL rst_mid_discard: out_valid=1 want 0 (a=%b b=%b)", e.a, e.b);
        else n_pass++;
        test_vector(4'b0101, 4'b1010, 8'hE2);
    endtask

    task automatic test_exhaustive();
        bit   acc;
        int   lat;
        exp_t e;
        int   bad_rows = 0;
        int   bad_prod = 0;
        for (int i = 0; i < 256; i++) begin
            send(4'(i >> 4), 4'(i), acc);
            wait_valid(lat);
            e = sb.pop_front();
            if (!acc || lat != 4 ||
                {bus_if.pp3, bus_if.pp2, bus_if.pp1, bus_if.pp0} !== {e.p3, e.p2, e.p1, e.p0}) begin
                if (bad_rows < 5)
                    $display("FAIL exh_rows a=%b b=%b: acc=%0d lat=%0d rows=%h want %h", e.a, e.b, acc, lat,
                             {bus_if.pp3, bus_if.pp2, bus_if.pp1, bus_if.pp0}, {e.p3, e.p2, e.p1, e.p0});
                bad_rows++;
            end
            if (reduce(bus_if.pp0, bus_if.pp1, bus_if.pp2, bus_if.pp3) !== smul(e.a, e.b)) begin
                if (bad_prod < 5)
                    $display("FAIL exh_product a=%b b=%b: product=%h want %h", e.a, e.b,
                             reduce(bus_if.pp0, bus_if.pp1, bus_if.pp2, bus_if.pp3), smul(e.a, e.b));
                bad_prod++;
            end
            finish_xfer();
        end
        n_total++;
        if (bad_rows != 0) $display("FAIL exh_rows_total: bad pairs=%0d want 0", bad_rows);
        else n_pass++;
        n_total++;
        if (bad_prod != 0) $display("FAIL exh_product_total: bad pairs=%0d want 0", bad_prod);
        else n_pass++;
    endtask

    initial begin
        #500000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        test_reset();
        test_vector(4'b1101, 4'b0101, 8'hF1);
        test_vector(4'b1000, 4'b1000, 8'h40);
        test_vector(4'b0111, 4'b1111, 8'hF9);
        test_backpressure();
        test_reset_mid_gen();
        test_exhaustive();
        $display("%0d/%0d checks passed", n_pass, n_total);
        $finish;
    end

endmodule

// File: doc/pp_gen_seq.md
PP_GEN_SEQ -- requirements
Module: pp_gen_seq

Purpose: sequential partial-product generator for the 4x4 signed (Baugh-Wooley) multiplier. It produces rows pp3..pp0, which feed the partial-product reduction stage directly.

Interface
REQ-001 SHALL have no parameters; all operand and row widths are fixed at 4 bits.
REQ-002 SHALL provide: clk  input  1  single clock; all state updates on the rising edge.
REQ-003 SHALL provide: rst  input  1  reset, synchronous and active-high.
REQ-004 SHALL provide: in_valid  input  1  operand pair a/b is valid.
REQ-005 SHALL provide: in_ready  output  1  block can accept operands.
REQ-006 SHALL provide: a  input  4  multiplicand, two's complement.
REQ-007 SHALL provide: b  input  4  multiplier, two's complement.
REQ-008 SHALL provide: out_valid  output  1  pp0..pp3 are complete and stable.
REQ-009 SHALL provide: out_ready  input  1  downstream consumes the rows.
REQ-010 SHALL provide: pp0, pp1, pp2, pp3  output  4 each  partial-product rows.

Function
REQ-011 SHALL implement three states: IDLE, GEN, HOLD.
REQ-012 Handshake signals SHALL be decoded from state:
- in_ready = (state==IDLE) and not rst.
- out_valid = (state==HOLD).
REQ-013 Accept SHALL occur on an edge where in_valid and in_ready are both high. On accept:
- latch a, b into a_q, b_q;
- clear pp0..pp3 to 0;
- clear row counter cnt (2 bit) to 0;
- go to GEN.
REQ-014 Each GEN edge SHALL write pp[cnt] = a_q AND {4{b_q[cnt]}}, then increment cnt.
REQ-015 The edge that writes pp3 (cnt==3) SHALL move the state to HOLD; cnt wraps to 0.
REQ-016 Latency SHALL be exactly 4 cycles: out_valid rises on the 4th edge after the accept edge.
REQ-017 pp3 SHALL be output uninverted. The downstream stage applies the inversion and the +8 correction, giving product = a*b mod 256.
REQ-018 In HOLD, pp0..pp3 SHALL stay stable while out_ready is low, for any number of cycles.
REQ-019 In HOLD, an edge with out_ready high SHALL complete the transfer; the next state is IDLE.
REQ-020 After a transfer, pp0..pp3 SHALL retain their values until the next accept.
REQ-021 in_valid, a and b SHALL be ignored in GEN and HOLD; a_q and b_q SHALL not change.
REQ-022 out_ready SHALL be ignored outside HOLD.
REQ-023 The block SHALL not overlap operations: minimum initiation interval is 6 cycles (accept, 4 GEN, HOLD handshake).

Reset
REQ-024 While rst is high at an edge, the block SHALL load state=IDLE, cnt=0, a_q=b_q=0 and pp0..pp3=0.
REQ-025 Output values during and after reset SHALL be: in_ready=0 while rst is high; out_valid=0; in_ready=1 on the first cycle after rst deasserts.
REQ-026 rst SHALL take priority over all other inputs, including mid-GEN and in HOLD. A partial result SHALL be discarded and never flagged valid.

Verification
REQ-027 The bench SHALL cover these scenarios:
- a=4'b1101 (-3), b=4'b0101 (5) -> 4 cycles after accept, pp0=1101, pp1=0000, pp2=1101, pp3=0000; via reduction, product 8'hF1.
- a=4'b1000 (-8), b=4'b1000 (-8) -> pp0=pp1=pp2=0000, pp3=1000; product 8'h40.
- a=4'b0111, b=4'b1111 -> all rows 0111; product 8'hF9.
- Backpressure: out_ready held low 3 cycles in HOLD -> out_valid=1 and rows unchanged. Then raise out_ready -> next cycle out_valid=0, in_ready=1. In the same run, toggle in_valid with new a/b during GEN -> result unaffected.
- rst pulsed 1 cycle on the 2nd GEN edge -> next cycle state IDLE, all pp=0, out_valid never asserted. A following operation produces the correct rows.
- Exhaustive: all 256 (a,b) pairs through the downstream reduction stage -> product equals the signed a*b for every pair.
